// File: rtl/pwm_bank.sv
// pwm_bank: shared-counter multi-channel PWM with shadowed registers.
// Edge- and center-aligned modes; new settings apply at period boundaries.
module pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic                period_start,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(CHANNELS + 1);

  logic [WIDTH-1:0] duty_sh  [CHANNELS];
  logic [WIDTH-1:0] duty_act [CHANNELS];
  logic [WIDTH-1:0] top_sh;
  logic [WIDTH-1:0] top_act;
  logic             mode_sh;
  logic             mode_act;
  logic             en_ctrl;
  logic             running;
  logic [WIDTH-1:0] cnt;
  logic             dir;
  logic [WIDTH-1:0] cnt_step;
  logic             dir_step;
  logic [WIDTH-1:0] cnt_nxt;
  logic             dir_nxt;
  logic             load;
  logic             ps_nxt;

  // Next counter position while running (dir: 0 up, 1 down)
  always_comb begin
    cnt_step = '0;
    dir_step = 1'b0;
    if (top_act == '0) begin
      cnt_step = '0;
    end else if (!mode_act) begin
      cnt_step = (cnt >= top_act) ? '0 : cnt + 1'b1;
    end else if (!dir && (cnt < top_act)) begin
      cnt_step = cnt + 1'b1;
    end else begin
      cnt_step = cnt - 1'b1;
      dir_step = (cnt_step != '0);
    end
  end

  // Run/idle sequencing: first enabled edge is a boundary, idle copies shadows
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = 1'b0;
    load    = 1'b1;
    ps_nxt  = 1'b0;
    if (en_ctrl && running) begin
      cnt_nxt = cnt_step;
      dir_nxt = dir_step;
      load    = (cnt_step == '0);
      ps_nxt  = (cnt_step == '0);
    end else if (en_ctrl) begin
      ps_nxt  = 1'b1;
    end
  end

  // Shadow register file written by the core
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= '0;
      top_sh  <= '1;
      mode_sh <= 1'b0;
      en_ctrl <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_addr == ADDR_W'(i)) duty_sh[i] <= wr_data;
      end
      if (wr_addr == ADDR_TOP) top_sh <= wr_data;
      if (wr_addr == ADDR_CTRL) begin
        en_ctrl <= wr_data[0];
        mode_sh <= wr_data[1];
      end
    end
  end

  // Active set, reloaded from shadows at boundaries or while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= '0;
      top_act  <= '1;
      mode_act <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= duty_sh[i];
      top_act  <= top_sh;
      mode_act <= mode_sh;
    end
  end

  // Counter, run flag and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      dir          <= 1'b0;
      running      <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= '0;
    end else begin
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      running      <= en_ctrl;
      period_start <= ps_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= running && (cnt < duty_act[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench for pwm_bank.
// Phase-based reference model predicts outputs; monitor compares each cycle.
module tb_pwm_bank;

  localparam int CH = 8;
  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          period_start;
  logic [CH-1:0] pwm_out;

  pwm_bank #(.CHANNELS(CH), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .period_start(period_start),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  logic [CH:0] q[$];
  int checks = 0;
  int errors = 0;

  int m_duty[CH];
  int m_top;
  bit m_mode;
  bit m_en;
  int a_duty[CH];
  int a_top;
  bit a_mode;
  bit a_run;
  int phase;

  function automatic int plen(int top, bit mode);
    if (top == 0) return 1;
    return mode ? 2 * top : top + 1;
  endfunction

  function automatic int cnt_of(int ph, int top, bit mode);
    if (!mode || ph <= top) return ph;
    return 2 * top - ph;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0;
      a_duty[i] = 0;
    end
    m_top  = 65535;
    a_top  = 65535;
    m_mode = 1'b0;
    a_mode = 1'b0;
    m_en   = 1'b0;
    a_run  = 1'b0;
    phase  = 0;
  endfunction

  function automatic void load_active();
    for (int i = 0; i < CH; i++) a_duty[i] = m_duty[i];
    a_top  = m_top;
    a_mode = m_mode;
  endfunction

  // Reference model: one step per clock edge, expectation queued
  always @(posedge clk) begin : mdl
    logic [CH:0] e;
    int c;
    int ad;
    if (reset) begin
      model_reset();
    end else begin
      c = cnt_of(phase, a_top, a_mode);
      for (int i = 0; i < CH; i++) e[i] = a_run && (c < a_duty[i]);
      e[CH] = 1'b0;
      if (!m_en) begin
        phase = 0;
        load_active();
      end else if (!a_run) begin
        phase = 0;
        load_active();
        e[CH] = 1'b1;
      end else begin
        phase = (phase + 1) % plen(a_top, a_mode);
        if (phase == 0) begin
          load_active();
          e[CH] = 1'b1;
        end
      end
      a_run = m_en;
      if (wr_en) begin
        ad = int'(wr_addr);
        if (ad < CH) m_duty[ad] = int'(wr_data);
        else if (ad == CH) m_top = int'(wr_data);
        else if (ad == CH + 1) begin
          m_en   = wr_data[0];
          m_mode = wr_data[1];
        end
      end
      q.push_back(e);
    end
  end

  // Monitor: pop one expectation per cycle away from the active edge
  always @(negedge clk) begin : mon
    logic [CH:0] e;
    logic [CH:0] got;
    if (!reset) begin
      checks++;
      got = {period_start, pwm_out};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty t=%0t got %b required an expectation", $time, got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb t=%0t {ps,pwm} got %b required %b", $time, got, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = W'(data);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    q.delete();
    model_reset();
    #1;
    checks++;
    if (pwm_out !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pwm=%b ps=%b required all 0", pwm_out, period_start);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    int a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle(3);
    // edge mode, TOP=4, duty0=2
    wr(CH, 4);
    wr(0, 2);
    wr(CH + 1, 1);
    idle(20);
    // duty change mid-period
    idle(1);
    wr(0, 4);
    idle(15);
    // center mode
    wr(0, 2);
    wr(CH + 1, 3);
    idle(24);
    // duty extremes
    wr(1, 0);
    wr(2, 16'hFFFF);
    idle(20);
    // TOP=0 then disable
    wr(CH, 0);
    idle(6);
    wr(CH + 1, 0);
    idle(6);
    // reset mid-period, then stay idle
    wr(CH, 4);
    wr(CH + 1, 1);
    idle(4);
    async_reset();
    idle(10);
    // randomized traffic
    repeat (3000) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else if (r < 3) begin
        a = $urandom_range(0, 15);
        if (a == CH + 1)
          wr(a, {$urandom_range(0, 1), int'($urandom_range(0, 7) != 0)});
        else if (a == CH)
          wr(a, $urandom_range(0, 10));
        else if (a < CH)
          wr(a, ($urandom_range(0, 9) == 0) ? 16'hFFFF : $urandom_range(0, 12));
        else
          wr(a, $urandom_range(0, 65535));
      end else begin
        idle(1);
      end
    end
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
